// File: rtl/mipi_tx_frame_arbiter_if.sv
// Requester / mipi_tx side signals of the TX frame arbiter.
interface mipi_tx_frame_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DLEN = 512
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DLEN*8-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        nack;
  logic                   busy;
  logic [DLEN*8-1:0]      pix_gen_data;
  logic                   write_enable;
  logic                   data_available;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                   active;
  logic [15:0]            timeout_cnt;

  // master: requesters plus mipi_tx; slave: the arbiter itself.
  modport master (
    output req, req_data, busy,
    input  ack, nack, pix_gen_data, write_enable, data_available, grant_id, active, timeout_cnt
  );
  modport slave (
    input  req, req_data, busy,
    output ack, nack, pix_gen_data, write_enable, data_available, grant_id, active, timeout_cnt
  );
endinterface

// File: rtl/mipi_tx_frame_arbiter.sv
// Round-robin arbiter sharing the MIPI TX frame path among NREQ requesters.
// Build option MIPI_TX_ARB_PRIO_EN: req[0] gets strict priority over the round-robin set.
module mipi_tx_frame_arbiter #(
  parameter int NREQ        = 4,
  parameter int DLEN        = 512,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int GAP_CYC     = 16
) (
  input  logic                   tx_pixel_clk,
  input  logic                   rst_n,
  mipi_tx_frame_arbiter_if.slave bus,
  output logic [2:0]             state_dbg
);
  localparam int GW   = $clog2(NREQ);
  localparam int PW   = DLEN * 8;
  localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_SEND, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr, rr_nxt, grant, pick;
  logic            pick_ok;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   pix;
  logic            we;
  logic [15:0]     tcnt;
  logic [NREQ-1:0] grant_oh;
  logic            frame_ack, frame_nack, frame_end;
  int              idx;

  // Handshake: req is a level held until its ack/nack pulse; write_enable is a
  // one-cycle strobe with pix_gen_data already valid; data_available holds until busy.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!pick_ok && bus.req[idx]) begin
        pick    = GW'(idx);
        pick_ok = 1'b1;
      end
    end
`ifdef MIPI_TX_ARB_PRIO_EN
    if (bus.req[0]) begin
      pick    = '0;
      pick_ok = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    frame_ack  = 1'b0;
    frame_nack = 1'b0;
    case (state)
      S_IDLE:  if (pick_ok) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START, S_SEND: begin
        // A frame that finishes on the timeout cycle still counts as sent.
        if (state == S_SEND && !bus.busy) frame_ack = 1'b1;
        else if (timer == TIMER_LAST)     frame_nack = 1'b1;
        else if (state == S_START && bus.busy) state_nxt = S_SEND;
        if (frame_ack || frame_nack) state_nxt = S_GAP;
      end
      S_GAP:   if (timer == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign frame_end = frame_ack || frame_nack;
  assign grant_oh  = NREQ'(1) << grant;
  assign rr_nxt    = (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);

  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rr    <= '0;
      grant <= '0;
      timer <= '0;
      pix   <= '0;
      we    <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      we    <= (state == S_LOAD);
      if (state == S_IDLE && pick_ok) grant <= pick;
      if (state == S_LOAD) pix <= bus.req_data[int'(grant)*PW +: PW];
      if (state == S_LOAD || frame_end) timer <= '0;
      else if (state == S_START || state == S_SEND || state == S_GAP) timer <= timer + 1'b1;
      if (frame_end) begin
`ifdef MIPI_TX_ARB_PRIO_EN
        if (grant != '0) rr <= rr_nxt;
`else
        rr <= rr_nxt;
`endif
      end
      if (frame_nack && tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
    end
  end

  assign bus.ack            = frame_ack  ? grant_oh : '0;
  assign bus.nack           = frame_nack ? grant_oh : '0;
  assign bus.write_enable   = we;
  assign bus.data_available = (state == S_START);
  assign bus.active         = (state == S_LOAD) || (state == S_START) || (state == S_SEND);
  assign bus.grant_id       = grant;
  assign bus.pix_gen_data   = pix;
  assign bus.timeout_cnt    = tcnt;
  assign state_dbg          = state;
endmodule

// File: tb/tb_mipi_tx_frame_arbiter.sv
// Directed bench for mipi_tx_frame_arbiter with a cycle-timeline reference model.
module tb_mipi_tx_frame_arbiter;
  localparam int NREQ = 4;
  localparam int DLEN = 8;
  localparam int PW   = DLEN * 8;
  localparam int GW   = 2;
  localparam int TOUT = 100;
  localparam int GAP  = 16;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;
  int         cyc;
  int         checks;
  int         failures;

  mipi_tx_frame_arbiter_if #(.NREQ(NREQ), .DLEN(DLEN)) bus ();

  mipi_tx_frame_arbiter #(
    .NREQ(NREQ), .DLEN(DLEN), .TIMEOUT_CYC(TOUT), .GAP_CYC(GAP)
  ) dut (
    .tx_pixel_clk(clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // busy responder modelling mipi_tx
  int busy_dly, busy_len;
  bit busy_en;
  initial begin
    bus.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_en && rst_n && bus.data_available && !bus.busy) begin
        repeat (busy_dly) @(posedge clk);
        #1 bus.busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.busy = 1'b0;
      end
    end
  end

  // reference model: frame timeline derived from the arbitration rules
  function automatic int arbitrate(input logic [NREQ-1:0] r, input int rrp);
`ifdef MIPI_TX_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(rrp + k) % NREQ]) return (rrp + k) % NREQ;
    return 0;
  endfunction

  int              m_mode, m_L, m_gap_end, m_rr, m_gid;
  bit              m_seen;
  logic [PW-1:0]   m_pix;
  logic [15:0]     m_tcnt;
  int              grant_log[$], we_log[$], done_log[$];
  logic [NREQ-1:0] ack_log[$], nack_log[$];
  logic [GW-1:0]   exp_q[$];

  initial begin : compare
    logic [NREQ-1:0] e_ack, e_nack;
    logic e_we, e_da, e_act;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_mode = 0; m_rr = 0; m_gid = 0; m_pix = '0; m_tcnt = '0; m_seen = 0;
        check("rst_outputs", {bus.ack, bus.nack, bus.write_enable, bus.data_available,
                              bus.active, bus.grant_id, bus.timeout_cnt}, '0);
        check("rst_pix", bus.pix_gen_data, '0);
      end else begin
        e_ack = '0; e_nack = '0; e_we = 0; e_da = 0; e_act = 0;
        if (m_mode == 1) begin
          e_act = 1;
          if (cyc == m_L + 1) e_we = 1;
          if (cyc >= m_L + 1) begin
            e_da = !m_seen;
            if (m_seen && !bus.busy)  e_ack  = NREQ'(1) << m_gid;
            else if (cyc == m_L + TOUT) e_nack = NREQ'(1) << m_gid;
          end
        end
        check("ack", bus.ack, e_ack);
        check("nack", bus.nack, e_nack);
        check("write_enable", bus.write_enable, e_we);
        check("data_available", bus.data_available, e_da);
        check("active", bus.active, e_act);
        check("grant_id", bus.grant_id, m_gid);
        check("pix_gen_data", bus.pix_gen_data, m_pix);
        check("timeout_cnt", bus.timeout_cnt, m_tcnt);
        if (bus.write_enable) begin grant_log.push_back(bus.grant_id); we_log.push_back(cyc); end
        if (bus.ack != 0)  begin ack_log.push_back(bus.ack);  done_log.push_back(cyc); end
        if (bus.nack != 0) begin nack_log.push_back(bus.nack); done_log.push_back(cyc); end
        case (m_mode)
          0: if (bus.req != 0) begin
               m_gid = arbitrate(bus.req, m_rr); m_L = cyc + 1; m_seen = 0; m_mode = 1;
             end
          1: if (cyc == m_L) m_pix = bus.req_data[m_gid*PW +: PW];
             else if (e_ack != 0 || e_nack != 0) begin
               if (e_nack != 0 && m_tcnt != 16'hFFFF) m_tcnt++;
`ifdef MIPI_TX_ARB_PRIO_EN
               if (m_gid != 0) m_rr = (m_gid + 1) % NREQ;
`else
               m_rr = (m_gid + 1) % NREQ;
`endif
               m_mode = 2; m_gap_end = cyc + GAP;
             end else if (!m_seen && bus.busy) m_seen = 1;
          default: if (cyc == m_gap_end) m_mode = 0;
        endcase
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); we_log.delete(); done_log.delete();
    ack_log.delete(); nack_log.delete(); exp_q.delete();
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*PW +: PW] = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    tick();
    tick();
    check("rst_lit_active", bus.active, 0);
    check("rst_lit_ack", bus.ack | bus.nack, 0);
    check("rst_lit_grant", bus.grant_id, 0);
    check("rst_lit_tcnt", bus.timeout_cnt, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] bits);
    bits = '0;
    for (int i = 0; i < budget && bits == 0; i++) begin
      @(negedge clk);
      bits = bus.ack | bus.nack;
    end
    if (bits == 0) begin
      checks++; failures++;
      $display("FAIL wait_done: no ack/nack within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int i;
    for (i = 0; i < budget && bus.busy !== lvl; i++) @(negedge clk);
    if (bus.busy !== lvl) begin
      checks++; failures++;
      $display("FAIL wait_busy: busy never reached %0b", lvl);
    end
  endtask

  task automatic serve(input int n, input bit hold);
    logic [NREQ-1:0] d;
    for (int i = 0; i < n; i++) begin
      wait_done(400, d);
      if (!hold) bus.req = bus.req & ~d;
    end
  endtask

  task automatic check_grants(input string name);
    check({name, "_count"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      check($sformatf("%s_%0d", name, i), grant_log[i], exp_q[i]);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin : main
    int req_cyc, t1_done;
    checks = 0; failures = 0;
    rst_n = 1'b0; bus.req = '0; busy_en = 1; busy_dly = 3; busy_len = 50;
    randomize_data();
    do_reset();

    // single request
    clear_logs();
    tick();
    req_cyc = cyc;
    bus.req = 4'b0100;
    serve(1, 0);
    check("t1_latency", at(we_log, 0) - req_cyc, 2);
    check("t1_grant", at(grant_log, 0), 2);
    check("t1_ack_count", ack_log.size(), 1);
    check("t1_ack_bits", (ack_log.size() > 0) ? ack_log[0] : '0, 4'b0100);
    t1_done = at(done_log, 0);

    // wrap from rr=3
    clear_logs();
    randomize_data();
    bus.req = 4'b0011;
    serve(2, 0);
    exp_q = '{2'd0, 2'd1};
    check_grants("t3_wrap");
    check("t3_gap", at(we_log, 0) - t1_done, GAP + 3);

    // fairness from reset
    do_reset();
    clear_logs();
    busy_dly = 1; busy_len = 10;
    bus.req = 4'b1111;
    serve(5, 1);
    bus.req = '0;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check_grants("t2_rr");
    check("t2_spacing", at(we_log, 1) - at(done_log, 0), GAP + 3);

    // timeout: rr=1, busy never rises for the first frame
    clear_logs();
    busy_en = 0;
    bus.req = 4'b0110;
    serve(1, 0);
    busy_en = 1;
    check("t4_nack_bits", (nack_log.size() > 0) ? nack_log[0] : '0, 4'b0010);
    check("t4_nack_time", at(done_log, 0) - (at(we_log, 0) - 1), TOUT);
    check("t4_tcnt", bus.timeout_cnt, 1);
    serve(1, 0);
    exp_q = '{2'd1, 2'd2};
    check_grants("t4_grants");
    check("t4_ack_bits", (ack_log.size() > 0) ? ack_log[0] : '0, 4'b0100);

    // reset mid-SEND
    clear_logs();
    busy_dly = 3; busy_len = 50;
    bus.req = 4'b1000;
    wait_busy(1'b1, 100);
    repeat (5) tick();
    do_reset();
    check("t5_no_ack", ack_log.size() + nack_log.size(), 0);
    wait_busy(1'b0, 100);
    tick();
    clear_logs();
    bus.req = 4'b1001;
    serve(2, 0);
    exp_q = '{2'd0, 2'd3};
    check_grants("t5_restart");

`ifdef MIPI_TX_ARB_PRIO_EN
    do_reset();
    clear_logs();
    bus.req = 4'b1110;
    wait_busy(1'b1, 100);
    bus.req = bus.req | 4'b0001;
    serve(4, 0);
    exp_q = '{2'd1, 2'd0, 2'd2, 2'd3};
    check_grants("t6_prio");
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
